// File: rtl/bscan_pkg.sv
// bscan_pkg: shared types and constants for the BSCANE2 user-DR oversampler.
//   DR_WIDTH_DEFAULT : default data-register length in bits
//   SHIFT_CNT_W      : width of the saturating shift-edge counter
//   dr_t             : data-register word at the default width
//   dr_state_t       : scan-sequence state
`timescale 1ns/1ps
package bscan_pkg;

  localparam int DR_WIDTH_DEFAULT = 32;
  localparam int SHIFT_CNT_W      = 16;

  typedef logic [DR_WIDTH_DEFAULT-1:0] dr_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    SHIFTING = 2'd2
  } dr_state_t;

endpackage

// File: rtl/bscan_dr_oversampler_sync_edge.sv
// sync_edge: STAGES-deep synchronizer for one asynchronous input, followed by
// a rising-edge detector whose output is registered.
//   clk, rst_n : sampling clock, async active-low reset
//   din        : raw asynchronous input
//   rise       : one-clk pulse, STAGES+1 clk after a 0->1 edge on din
`timescale 1ns/1ps
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;
  logic              rise_r;

  // Synchronizer chain plus previous-level register and registered rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
      prev_r  <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
      prev_r  <= chain_r[STAGES-1];
      rise_r  <= chain_r[STAGES-1] & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/bscan_dr_oversampler.sv
// bscan_dr_oversampler: DR_WIDTH-bit JTAG user data register driven by
// oversampled BSCANE2 outputs in the clk domain.
//   clk, rst_n      : sampling clock (>= 8x TCK), async active-low reset
//   tck, tdi, sel, capture, shift, update, tlr : raw BSCANE2 outputs
//   capture_word    : word loaded at Capture-DR
//   tdo             : serial output, always equal to shreg[0]
//   update_word     : last word shifted in, held until the next update
//   update_valid    : one-clk pulse when update_word is written
//   length_err      : sticky, shift count != DR_WIDTH at update; cleared at capture
//   shift_count     : saturating TCK shift edges since last capture
`timescale 1ns/1ps
module bscan_dr_oversampler
  import bscan_pkg::*;
#(
  parameter int DR_WIDTH    = DR_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tck,
  input  logic                   tdi,
  input  logic                   sel,
  input  logic                   capture,
  input  logic                   shift,
  input  logic                   update,
  input  logic                   tlr,
  input  logic [DR_WIDTH-1:0]    capture_word,
  output logic                   tdo,
  output logic [DR_WIDTH-1:0]    update_word,
  output logic                   update_valid,
  output logic                   length_err,
  output logic [SHIFT_CNT_W-1:0] shift_count
);

  localparam int                     LVL_N   = 5;
  localparam logic [SHIFT_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SHIFT_CNT_W-1:0] CNT_DR  = SHIFT_CNT_W'(DR_WIDTH);

  logic                               tck_rise;
  logic                               upd_rise;
  logic [SYNC_STAGES-1:0][LVL_N-1:0]  lvl_chain_r;
  logic                               tdi_s, sel_s, capture_s, shift_s, tlr_s;

  dr_state_t                          state_r, state_nxt;
  logic [DR_WIDTH-1:0]                shreg_r, shreg_nxt;
  logic [DR_WIDTH-1:0]                word_r, word_nxt;
  logic [SHIFT_CNT_W-1:0]             cnt_r, cnt_nxt;
  logic                               err_r, err_nxt;
  logic                               valid_r, valid_nxt;
  logic                               tdo_r;

  sync_edge #(.STAGES(SYNC_STAGES)) u_tck_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tck),
    .rise  (tck_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_upd_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (update),
    .rise  (upd_rise)
  );

  // Level-only TAP inputs: synchronizer chain, no edge detection.
  // Their outputs lead the registered edge pulses by one clk, which is harmless
  // because these levels are stable for half a TCK period around each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_chain_r <= '0;
    end else begin
      lvl_chain_r[0] <= {tlr, shift, capture, sel, tdi};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        lvl_chain_r[i] <= lvl_chain_r[i-1];
      end
    end
  end

  assign {tlr_s, shift_s, capture_s, sel_s, tdi_s} = lvl_chain_r[SYNC_STAGES-1];

  // Scan-sequence next state; test-logic-reset and update both return to IDLE
  always_comb begin
    state_nxt = state_r;
    if (tlr_s) begin
      state_nxt = IDLE;
    end else if (upd_rise && sel_s) begin
      state_nxt = IDLE;
    end else if (tck_rise && sel_s && capture_s) begin
      state_nxt = CAPTURED;
    end else begin
      case (state_r)
        IDLE:     state_nxt = IDLE;
        CAPTURED: begin
          if (tck_rise && sel_s && shift_s) begin
            state_nxt = SHIFTING;
          end else begin
            state_nxt = CAPTURED;
          end
        end
        SHIFTING: state_nxt = SHIFTING;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Datapath next values: capture beats shift, and an update in the same clk
  // sees the post-shift register and count
  always_comb begin
    shreg_nxt = shreg_r;
    cnt_nxt   = cnt_r;
    err_nxt   = err_r;
    word_nxt  = word_r;
    valid_nxt = 1'b0;
    if (tlr_s) begin
      shreg_nxt = '0;
      cnt_nxt   = '0;
    end else begin
      if (tck_rise && sel_s && capture_s) begin
        shreg_nxt = capture_word;
        cnt_nxt   = '0;
        err_nxt   = 1'b0;
      end else if (tck_rise && sel_s && shift_s) begin
        shreg_nxt = {tdi_s, shreg_r[DR_WIDTH-1:1]};
        if (cnt_r != CNT_MAX) begin
          cnt_nxt = cnt_r + SHIFT_CNT_W'(1);
        end else begin
          cnt_nxt = cnt_r;
        end
      end else begin
        shreg_nxt = shreg_r;
      end
      if (upd_rise && sel_s) begin
        word_nxt  = shreg_nxt;
        valid_nxt = 1'b1;
        err_nxt   = (cnt_nxt != CNT_DR);
      end else begin
        valid_nxt = 1'b0;
      end
    end
  end

  // State, shift register and output registers; tdo tracks the next shreg LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      shreg_r <= '0;
      word_r  <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
      tdo_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      shreg_r <= shreg_nxt;
      word_r  <= word_nxt;
      cnt_r   <= cnt_nxt;
      err_r   <= err_nxt;
      valid_r <= valid_nxt;
      tdo_r   <= shreg_nxt[0];
    end
  end

  assign tdo          = tdo_r;
  assign update_word  = word_r;
  assign update_valid = valid_r;
  assign length_err   = err_r;
  assign shift_count  = cnt_r;

endmodule

// File: tb/tb_bscan_dr_oversampler.sv
`timescale 1ns/1ps
module tb_bscan_dr_oversampler;
  import bscan_pkg::*;

  localparam int W  = 32;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n, tck, tdi, sel, capture, shift, update, tlr;
  dr_t         capture_word;
  logic        tdo;
  dr_t         update_word;
  logic        update_valid, length_err;
  logic [15:0] shift_count;

  int          checks = 0;
  int          errors = 0;
  int          vcount = 0;
  dr_t         vword  = '0;

  // reference model state
  logic [31:0] exp_word, exp_cnt;
  logic        exp_err, exp_tdo;

  always #5 clk = ~clk;

  bscan_dr_oversampler #(.DR_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tck          (tck),
    .tdi          (tdi),
    .sel          (sel),
    .capture      (capture),
    .shift        (shift),
    .update       (update),
    .tlr          (tlr),
    .capture_word (capture_word),
    .tdo          (tdo),
    .update_word  (update_word),
    .update_valid (update_valid),
    .length_err   (length_err),
    .shift_count  (shift_count)
  );

  // update_valid pulse counter, sampled away from the active edge
  always @(negedge clk) begin
    if (update_valid === 1'b1) begin
      vcount = vcount + 1;
      vword  = update_word;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture-DR edge followed by n Shift-DR edges at TCK = 10 MHz; tdo is
  // checked before every shifting edge against the concatenated bit stream.
  task automatic cap_and_shift(input dr_t cap, input dr_t din, input int n, input logic s);
    logic [63:0] stream;
    stream       = {din, cap};
    sel          = s;
    capture_word = cap;
    capture      = 1'b1;
    #50 tck = 1'b1;
    #50 tck = 1'b0;
    capture = 1'b0;
    shift   = 1'b1;
    if (s) begin
      exp_cnt = 0;
      exp_err = 1'b0;
      exp_tdo = cap[0];
    end
    for (int i = 0; i < n; i++) begin
      tdi = din[i];
      #50;
      if (s) check("tdo_bit", {31'd0, tdo}, {31'd0, stream[i]});
      else   check("tdo_held", {31'd0, tdo}, {31'd0, exp_tdo});
      tck = 1'b1;
      #50 tck = 1'b0;
      if (s && exp_cnt != 32'hFFFF) exp_cnt = exp_cnt + 1;
    end
    shift = 1'b0;
    tdi   = 1'b0;
    if (s) exp_tdo = stream[n];
  endtask

  task automatic scan(input dr_t cap, input dr_t din, input int n, input logic s);
    int          v0;
    logic [63:0] tmp;
    cap_and_shift(cap, din, n, s);
    v0 = vcount;
    #50 update = 1'b1;
    #200 update = 1'b0;
    #100;
    if (s) begin
      tmp      = {din, cap} >> n;
      exp_word = tmp[31:0];
      exp_err  = (n != W);
    end
    check("valid_pulses", vcount - v0, s ? 32'd1 : 32'd0);
    if (s) check("valid_word", vword, exp_word);
    check("update_word", update_word, exp_word);
    check("length_err", {31'd0, length_err}, {31'd0, exp_err});
    check("shift_count", {16'd0, shift_count}, exp_cnt);
    check("tdo_after", {31'd0, tdo}, {31'd0, exp_tdo});
  endtask

  task automatic capture_only(input dr_t cap);
    sel          = 1'b1;
    capture_word = cap;
    capture      = 1'b1;
    #50 tck = 1'b1;
    #50 tck = 1'b0;
    capture = 1'b0;
    #100;
    exp_cnt = 0;
    exp_err = 1'b0;
    exp_tdo = cap[0];
    check("cap_err_clr", {31'd0, length_err}, {31'd0, exp_err});
    check("cap_cnt_clr", {16'd0, shift_count}, exp_cnt);
    check("cap_tdo", {31'd0, tdo}, {31'd0, exp_tdo});
  endtask

  initial begin
    dr_t  c, d;
    int   lat, v0;
    logic seen;

    rst_n = 1'b0; tck = 1'b0; tdi = 1'b0; sel = 1'b0; capture = 1'b0;
    shift = 1'b0; update = 1'b0; tlr = 1'b0; capture_word = '0;
    exp_word = '0; exp_cnt = '0; exp_err = 1'b0; exp_tdo = 1'b0;

    // all stimulus changes land 2 ns after a falling clk edge
    #22;
    check("rst_tdo", {31'd0, tdo}, 32'd0);
    check("rst_word", update_word, 32'd0);
    check("rst_valid", {31'd0, update_valid}, 32'd0);
    check("rst_err", {31'd0, length_err}, 32'd0);
    check("rst_cnt", {16'd0, shift_count}, 32'd0);
    rst_n = 1'b1;
    #100;

    // sel low: nothing may change
    scan(32'h1234_5678, 32'hCAFE_F00D, 32, 1'b0);

    // nominal scan
    scan(32'hA5A5_0F0F, 32'hDEAD_BEEF, 32, 1'b1);

    // random scans, some of them short
    for (int k = 0; k < 4; k++) begin
      c = $urandom;
      d = $urandom;
      scan(c, d, $urandom_range(24, 32), 1'b1);
    end

    // 31-bit short scan, then a capture clears the error
    c = $urandom;
    d = $urandom;
    scan(c, d, 31, 1'b1);
    capture_only($urandom);

    // raw TCK rise to tdo change: tdo moves from cap[0]=0 to cap[1]=1
    capture_only(32'h0000_0002);
    shift = 1'b1;
    tdi   = 1'b0;
    #50 tck = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (tdo === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("tdo_latency", lat, SS + 2);
    @(posedge clk);
    #7;
    #50 tck = 1'b0;
    #50 shift = 1'b0;

    // tlr in mid-shift: count and shift register cleared, update data held
    c = $urandom;
    d = $urandom;
    cap_and_shift(c, d, 10, 1'b1);
    #50 tlr = 1'b1;
    #100 tlr = 1'b0;
    #100;
    exp_cnt = 0;
    exp_tdo = 1'b0;
    check("tlr_cnt", {16'd0, shift_count}, exp_cnt);
    check("tlr_tdo", {31'd0, tdo}, {31'd0, exp_tdo});
    check("tlr_word", update_word, exp_word);
    check("tlr_err", {31'd0, length_err}, {31'd0, exp_err});

    // reset during a scan: outputs clear at once, no update follows
    v0 = vcount;
    cap_and_shift(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b1);
    #20 rst_n = 1'b0;
    #1;
    check("arst_tdo", {31'd0, tdo}, 32'd0);
    check("arst_word", update_word, 32'd0);
    check("arst_valid", {31'd0, update_valid}, 32'd0);
    check("arst_err", {31'd0, length_err}, 32'd0);
    check("arst_cnt", {16'd0, shift_count}, 32'd0);
    #29;
    shift = 1'b1;
    for (int i = 0; i < 22; i++) begin
      #50 tck = 1'b1;
      #50 tck = 1'b0;
    end
    shift = 1'b0;
    #50 update = 1'b1;
    #200 update = 1'b0;
    rst_n = 1'b1;
    #200;
    exp_word = '0; exp_cnt = '0; exp_err = 1'b0; exp_tdo = 1'b0;
    check("arst_no_valid", vcount - v0, 32'd0);
    check("arst_word_after", update_word, exp_word);
    check("arst_cnt_after", {16'd0, shift_count}, exp_cnt);

    // shift-count saturation with fast TCK (one clk high, one clk low)
    capture_only($urandom);
    shift = 1'b1;
    for (int i = 0; i < 65545; i++) begin
      tdi = $urandom_range(0, 1);
      tck = 1'b1;
      #10 tck = 1'b0;
      #10;
      if (i == 39999) begin
        #100;
        check("cnt_40000", {16'd0, shift_count}, 32'd40000);
      end
      if (i == 65533) begin
        #100;
        check("cnt_65534", {16'd0, shift_count}, 32'hFFFE);
      end
      if (i == 65534) begin
        #100;
        check("cnt_65535", {16'd0, shift_count}, 32'hFFFF);
      end
    end
    #100;
    check("cnt_saturated", {16'd0, shift_count}, 32'hFFFF);
    shift = 1'b0;
    #100;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
